// File: rtl/map_heap_pkg.sv
// map_heap_pkg: shared MAP heap constants and clear-sequencer state encoding
package map_heap_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  typedef enum logic {IDLE, CLEAR} heap_state_t;
endpackage

// File: rtl/heap_ram.sv
// heap_ram: single synchronous write port, two asynchronous read ports
module heap_ram
  import map_heap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/heap_stack.sv
// heap_stack: random-access heap with an upward-growing hardware stack and a zero-fill clear sequencer
module heap_stack
  import map_heap_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int STACK_DEPTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] iData,
  output logic [DATA_W-1:0] oData,
  input  logic              PUSH,
  input  logic              POP,
  input  logic              CLR,
  output logic [DATA_W-1:0] oTop,
  output logic [ADDR_W:0]   SP,
  output logic              FULL,
  output logic              EMPTY,
  output logic              BUSY,
  output logic              ERR
);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(2**ADDR_W - 1);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(STACK_DEPTH);
  heap_state_t       state_q, state_d;
  logic [ADDR_W:0]   sp_q, sp_d, idx_q, idx_d;
  logic [DATA_W-1:0] top_q, top_d, top_rd, wdata;
  logic              err_q, err_d, we;
  logic [ADDR_W-1:0] waddr, top_addr;
  assign top_addr = ADDR_W'(sp_q - ONE);
  assign FULL     = sp_q == DEPTH;
  assign EMPTY    = sp_q == '0;
  assign BUSY     = state_q == CLEAR;
  assign SP       = sp_q;
  assign oTop     = top_q;
  assign ERR      = err_q;
  heap_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk    (CLK),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr_a(ADDR),
    .rdata_a(oData),
    .raddr_b(top_addr),
    .rdata_b(top_rd)
  );
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    top_d   = top_q;
    err_d   = err_q;
    idx_d   = idx_q;
    we      = 1'b0;
    waddr   = ADDR;
    wdata   = iData;
    if (state_q == CLEAR) begin
      we      = 1'b1;
      waddr   = ADDR_W'(idx_q);
      wdata   = '0;
      idx_d   = idx_q + ONE;
      state_d = idx_q == LAST ? IDLE : CLEAR;
    end else if (CLR) begin
      state_d = CLEAR;
      sp_d    = '0;
      err_d   = 1'b0;
      top_d   = '0;
      idx_d   = '0;
    end else if (PUSH && POP) begin
      // replace-top keeps SP, so it stays legal even when the stack is full
      if (EMPTY) err_d = 1'b1;
      else begin
        top_d = top_rd;
        we    = 1'b1;
        waddr = top_addr;
      end
    end else if (PUSH) begin
      if (FULL) err_d = 1'b1;
      else begin
        we    = 1'b1;
        waddr = ADDR_W'(sp_q);
        sp_d  = sp_q + ONE;
      end
    end else if (POP) begin
      if (EMPTY) err_d = 1'b1;
      else begin
        top_d = top_rd;
        sp_d  = sp_q - ONE;
      end
    end else if (WR) we = 1'b1;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sp_q    <= '0;
      top_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      top_q   <= top_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_heap_stack.sv
// tb_heap_stack: directed checks of heap_stack with a scoreboard for popped values
module tb_heap_stack;
  logic       CLK = 1'b0, RST = 1'b1, WR = 1'b0, PUSH = 1'b0, POP = 1'b0, CLR = 1'b0;
  logic [4:0] ADDR = '0;
  logic [7:0] iData = '0, oData, oTop;
  logic [5:0] SP;
  logic       FULL, EMPTY, BUSY, ERR;
  int errors = 0, checks = 0;
  logic [7:0] stk[$];
  logic [7:0] sb[$];
  logic [7:0] img[32];

  heap_stack dut (
    .CLK(CLK), .RST(RST), .WR(WR), .ADDR(ADDR), .iData(iData), .oData(oData),
    .PUSH(PUSH), .POP(POP), .CLR(CLR), .oTop(oTop), .SP(SP),
    .FULL(FULL), .EMPTY(EMPTY), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [7:0] d);
    PUSH = 1'b1; iData = d; tick(); PUSH = 1'b0;
    stk.push_back(d);
  endtask

  task automatic pop();
    POP = 1'b1; sb.push_back(stk.pop_back()); tick(); POP = 1'b0;
    chk("pop_top", oTop, sb.pop_front());
  endtask

  task automatic write(logic [4:0] a, logic [7:0] d);
    WR = 1'b1; ADDR = a; iData = d; tick(); WR = 1'b0;
  endtask

  task automatic fill_img();
    for (int i = 0; i < 32; i++) begin
      img[i] = 8'h80 + 8'(i);
      write(5'(i), img[i]);
    end
  endtask

  initial begin
    int n;
    #12;
    chk("rst_sp", SP, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR, 0);
    chk("rst_top", oTop, 0);
    RST = 1'b0;
    tick();
    write(5'd3, 8'hA5);
    ADDR = 5'd3; #1;
    chk("rd_a5", oData, 8'hA5);
    chk("wr_sp", SP, 0);
    chk("wr_empty", EMPTY, 1);
    push(8'h11); push(8'h22); push(8'h33);
    chk("push3_sp", SP, 3);
    pop(); chk("sp_2", SP, 2);
    pop(); chk("sp_1", SP, 1);
    pop(); chk("sp_0", SP, 0);
    chk("drain_empty", EMPTY, 1);
    chk("drain_err", ERR, 0);
    for (int i = 0; i < 32; i++) begin
      chk("fill_notfull", FULL, 0);
      push(8'h40 + 8'(i));
    end
    chk("full", FULL, 1);
    chk("full_sp", SP, 32);
    chk("full_err0", ERR, 0);
    PUSH = 1'b1; iData = 8'hEE; tick(); PUSH = 1'b0;
    chk("ovf_sp", SP, 32);
    chk("ovf_err", ERR, 1);
    ADDR = 5'd31; #1;
    chk("ovf_mem31", oData, 8'h5F);
    for (int i = 0; i < 32; i++) pop();
    chk("drained_empty", EMPTY, 1);
    POP = 1'b1; tick(); POP = 1'b0;
    chk("udf_sp", SP, 0);
    chk("udf_top", oTop, 8'h40);
    chk("udf_err", ERR, 1);
    push(8'h11); push(8'h22);
    PUSH = 1'b1; POP = 1'b1; iData = 8'h99;
    sb.push_back(stk[$]); stk[$] = 8'h99;
    tick(); PUSH = 1'b0; POP = 1'b0;
    chk("repl_top", oTop, sb.pop_front());
    chk("repl_sp", SP, 2);
    ADDR = 5'd1; #1;
    chk("repl_mem1", oData, 8'h99);
    pop(); pop();
    fill_img();
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("clr_busy", BUSY, 1);
    chk("clr_sp", SP, 0);
    chk("clr_err", ERR, 0);
    chk("clr_top", oTop, 0);
    WR = 1'b1; PUSH = 1'b1; ADDR = 5'd0; iData = 8'hFF;
    n = 0;
    while (BUSY && n < 100) begin tick(); n++; end
    WR = 1'b0; PUSH = 1'b0;
    chk("busy_cycles", n, 32);
    chk("post_sp", SP, 0);
    chk("post_err", ERR, 0);
    chk("post_top", oTop, 0);
    for (int i = 0; i < 32; i++) begin
      ADDR = 5'(i); #1;
      chk("cleared", oData, 0);
    end
    PUSH = 1'b1; POP = 1'b1; tick(); PUSH = 1'b0; POP = 1'b0;
    chk("pp_empty_err", ERR, 1);
    chk("pp_empty_sp", SP, 0);
    fill_img();
    CLR = 1'b1; tick(); CLR = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_busy", BUSY, 1);
    RST = 1'b1; #1;
    chk("async_busy", BUSY, 0);
    chk("async_sp", SP, 0);
    #1 RST = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ADDR = 5'(i); #1;
      chk("partial", oData, i < 10 ? 32'h0 : 32'(img[i]));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
